// File: rtl/opb_sw_reg_pkg.sv
// Shared definitions for the OPB software-register slaves.
// Covers the register map, the slave FSM states and the STATUS word layout.
package opb_sw_reg_pkg;

    localparam int unsigned DATA_W    = 32;
    localparam int unsigned OVR_W     = 16;
    localparam int unsigned OFF_IDX_W = 3;
    localparam int unsigned OFF_W     = OFF_IDX_W + 2;

    localparam logic [OFF_W-1:0] OFF_DATA   = 5'h00;
    localparam logic [OFF_W-1:0] OFF_STATUS = 5'h04;

    localparam int unsigned ST_FRESH_BIT = 0;
    localparam int unsigned ST_OVR_LSB   = 16;

    localparam logic [OVR_W-1:0] OVR_MAX = 16'hFFFF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACK  = 2'd1,
        HOLD = 2'd2
    } ack_state_e;

    typedef struct packed {
        logic [OVR_W-1:0] overrun_cnt;
        logic [14:0]      rsvd;
        logic             fresh;
    } status_t;

    function automatic logic [OVR_W-1:0] sat_inc(input logic [OVR_W-1:0] v);
        return (v == OVR_MAX) ? OVR_MAX : v + OVR_W'(1);
    endfunction

endpackage

// File: rtl/opb_slave_ack_fsm.sv
// OPB slave address decode and IDLE/ACK/HOLD acknowledge sequencing.
// rd_en_o/wr_en_o/ack_cycle_o are high only during the single ACK cycle.
module opb_slave_ack_fsm
    import opb_sw_reg_pkg::*;
#(
    parameter logic [31:0] BASEADDR = 32'hFFFF_FFFF,
    parameter logic [31:0] HIGHADDR = 32'h0000_0000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 select_i,
    input  logic                 rnw_i,
    input  logic [31:0]          addr_i,
    output logic                 start_c,
    output logic [OFF_IDX_W-1:0] offset_c,
    output logic                 ack_cycle_o,
    output logic                 rd_en_o,
    output logic                 wr_en_o,
    output logic [OFF_IDX_W-1:0] offset_o
);

    localparam logic [31:0] ADDR_MASK = ~(HIGHADDR ^ BASEADDR);

    ack_state_e           state_q, state_d;
    logic                 ack_d, rd_en_d, wr_en_d;
    logic [OFF_IDX_W-1:0] offset_d;
    logic                 hit_c;

    assign hit_c    = ((addr_i & ADDR_MASK) == BASEADDR);
    assign offset_c = addr_i[4:2];
    assign start_c  = (state_q == IDLE) && select_i && hit_c;

    // State and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            ack_cycle_o <= 1'b0;
            rd_en_o     <= 1'b0;
            wr_en_o     <= 1'b0;
            offset_o    <= '0;
        end else begin
            state_q     <= state_d;
            ack_cycle_o <= ack_d;
            rd_en_o     <= rd_en_d;
            wr_en_o     <= wr_en_d;
            offset_o    <= offset_d;
        end
    end

    // Next state; HOLD absorbs the master's late select deassert
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start_c) state_d = ACK;
            ACK:     state_d = HOLD;
            HOLD:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output next values, registered alongside the state
    always_comb begin
        ack_d    = (state_d == ACK);
        rd_en_d  = start_c && rnw_i;
        wr_en_d  = start_c && !rnw_i;
        offset_d = start_c ? offset_c : offset_o;
    end

endmodule

// File: rtl/opb_register_simulink2ppc.sv
// User-logic-to-PowerPC software register on OPB: DATA word plus STATUS
// (fresh flag, saturating overrun counter) so software can spot missed updates.
module opb_register_simulink2ppc
    import opb_sw_reg_pkg::*;
#(
    parameter logic [31:0] C_BASEADDR    = 32'hFFFF_FFFF,
    parameter logic [31:0] C_HIGHADDR    = 32'h0000_0000,
    parameter int unsigned C_OPB_AWIDTH  = 32,
    parameter int unsigned C_OPB_DWIDTH  = 32,
    parameter              C_FAMILY      = "virtex6",
    parameter logic [31:0] C_RESET_VALUE = 32'h0000_0000
) (
    input  logic                    OPB_Clk,
    input  logic                    OPB_Rst_n,
    output logic [0:C_OPB_DWIDTH-1] Sl_DBus,
    output logic                    Sl_errAck,
    output logic                    Sl_retry,
    output logic                    Sl_toutSup,
    output logic                    Sl_xferAck,
    input  logic [0:C_OPB_AWIDTH-1] OPB_ABus,
    input  logic [0:3]              OPB_BE,
    input  logic [0:C_OPB_DWIDTH-1] OPB_DBus,
    input  logic                    OPB_RNW,
    input  logic                    OPB_select,
    input  logic                    OPB_seqAddr,
    input  logic [31:0]             user_data_in,
    input  logic                    user_data_valid
);

    logic                 start_c, ack_cycle, rd_en, wr_en;
    logic [OFF_IDX_W-1:0] offset_c, offset_q;

    logic [DATA_W-1:0] data_q, data_d;
    logic [DATA_W-1:0] rd_q, rd_d;
    logic [OVR_W-1:0]  ovr_q, ovr_d;
    logic              fresh_q, fresh_d;
    logic [3:0]        be_q, be_d;
    logic [DATA_W-1:0] snap_c;
    logic              clr_fresh_c, clr_ovr_c;
    logic              unused_ok;

    opb_slave_ack_fsm #(
        .BASEADDR (C_BASEADDR),
        .HIGHADDR (C_HIGHADDR)
    ) u_fsm (
        .clk         (OPB_Clk),
        .rst_n       (OPB_Rst_n),
        .select_i    (OPB_select),
        .rnw_i       (OPB_RNW),
        .addr_i      (OPB_ABus),
        .start_c     (start_c),
        .offset_c    (offset_c),
        .ack_cycle_o (ack_cycle),
        .rd_en_o     (rd_en),
        .wr_en_o     (wr_en),
        .offset_o    (offset_q)
    );

    assign Sl_errAck  = 1'b0;
    assign Sl_retry   = 1'b0;
    assign Sl_toutSup = 1'b0;
    assign Sl_xferAck = ack_cycle;
    // rd_q is nonzero only during ACK, keeping the OR-bus clean; OPB bit 0 = MSB
    assign Sl_DBus    = rd_q;
    assign unused_ok  = ^{OPB_seqAddr, OPB_DBus, C_FAMILY};

    assign clr_fresh_c = rd_en && ({offset_q, 2'b00} == OFF_DATA);
    assign clr_ovr_c   = wr_en && ({offset_q, 2'b00} == OFF_STATUS) && (|be_q);

    // Read snapshot taken when the transfer is accepted
    always_comb begin
        snap_c = '0;
        case ({offset_c, 2'b00})
            OFF_DATA:   snap_c = data_q;
            OFF_STATUS: snap_c = status_t'{overrun_cnt: ovr_q, rsvd: '0, fresh: fresh_q};
            default:    snap_c = '0;
        endcase
    end

    // Register updates; user set beats read-clear, STATUS clear beats increment
    always_comb begin
        data_d  = data_q;
        fresh_d = fresh_q;
        ovr_d   = ovr_q;
        be_d    = start_c ? OPB_BE : be_q;
        rd_d    = (start_c && OPB_RNW) ? snap_c : '0;
        if (user_data_valid) begin
            data_d  = user_data_in;
            fresh_d = 1'b1;
            if (fresh_q && !clr_fresh_c) begin
                ovr_d = sat_inc(ovr_q);
            end
        end else if (clr_fresh_c) begin
            fresh_d = 1'b0;
        end
        if (clr_ovr_c) begin
            ovr_d = '0;
        end
    end

    always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
        if (!OPB_Rst_n) begin
            data_q  <= C_RESET_VALUE;
            fresh_q <= 1'b0;
            ovr_q   <= '0;
            rd_q    <= '0;
            be_q    <= '0;
        end else begin
            data_q  <= data_d;
            fresh_q <= fresh_d;
            ovr_q   <= ovr_d;
            rd_q    <= rd_d;
            be_q    <= be_d;
        end
    end

endmodule

// File: doc/opb_register_simulink2ppc.md
Name: opb_register_simulink2ppc

Overview:
- User-logic-to-processor software register: user logic in the OPB_Clk domain presents a 32-bit word with a valid strobe, and the PowerPC reads it over OPB.
- Sits on the same OPB bus as the ppc2simulink registers and provides the opposite data direction.
- Adds a freshness flag and a saturating overrun counter so software can detect missed updates.

Parameters:
- C_BASEADDR, 32'hFFFFFFFF: OPB base address, 256-byte aligned.
- C_HIGHADDR, 32'h00000000: OPB high address; the window is C_BASEADDR..C_HIGHADDR.
- C_OPB_AWIDTH, 32: OPB address width.
- C_OPB_DWIDTH, 32: OPB data width; only 32 is supported.
- C_FAMILY, "virtex6": target family, passed through and not otherwise used.
- C_RESET_VALUE, 32'h00000000: reset value of the data holding register.

Ports:
- OPB_Clk  in  1  sole clock; the OPB bus and user logic both run on it.
- OPB_Rst_n  in  1  reset, asynchronous assert, active-low.
- Sl_DBus  out  [0:31]  read data; all zeros whenever Sl_xferAck is low (OR-bus).
- Sl_errAck  out  1  tied 0.
- Sl_retry  out  1  tied 0.
- Sl_toutSup  out  1  tied 0.
- Sl_xferAck  out  1  one-cycle transfer acknowledge.
- OPB_ABus  in  [0:31]  address.
- OPB_BE  in  [0:3]  byte enables.
- OPB_DBus  in  [0:31]  write data.
- OPB_RNW  in  1  1 = read, 0 = write.
- OPB_select  in  1  transfer in progress.
- OPB_seqAddr  in  1  ignored.
- user_data_in  in  [31:0]  word from user logic.
- user_data_valid  in  1  capture strobe for user_data_in.

Behaviour:
- Decided: one clock, OPB_Clk; reset OPB_Rst_n is asynchronous and active-low.
- Register map, byte offsets from C_BASEADDR:
  - 0x0 DATA: read-only; writes are acked and ignored.
  - 0x4 STATUS: read returns fresh in bit[0] and overrun_cnt in bits[31:16]; bits[15:1] read 0.
  - 0x4 STATUS write: when any OPB_BE bit is set, clears overrun_cnt; fresh is unaffected.
  - Other offsets in the window: acked; read 0; writes ignored.
- Bit mapping: Sl_DBus[i] = word[31-i], so OPB bit 0 is the MSB.
- Address hit: (OPB_ABus & ~(C_HIGHADDR ^ C_BASEADDR)) == C_BASEADDR. Offset = OPB_ABus[27:29].
- User capture, every cycle with user_data_valid=1:
  - data_reg <= user_data_in.
  - fresh <= 1.
  - If fresh was already 1 and is not being cleared this cycle, overrun_cnt <= sat16(overrun_cnt+1).
- Slave FSM states IDLE, ACK, HOLD:
  - IDLE: if OPB_select and hit, latch the read word (snapshot of the current register values) into rd_reg and go to ACK. Otherwise stay.
  - ACK: Sl_xferAck=1 and Sl_DBus=rd_reg (zeros on a write) for exactly one cycle. Write side effects apply on this cycle's edge. A read of DATA clears fresh on this edge. Next state HOLD.
  - HOLD: one dead cycle with Sl_xferAck=0, then IDLE. This absorbs the master's select-deassert lag, so no double-ack is possible.
- Latency: select sampled at edge k gives Sl_xferAck high in cycle k+1. Minimum spacing between acks is 3 cycles.
- Simultaneous DATA read ack and user_data_valid:
  - The read returns the snapshot taken in IDLE.
  - The new data is stored and fresh ends at 1; the set wins over the read-clear.
  - No overrun increment on that cycle.
- Simultaneous STATUS clear write and an overrun increment: the clear wins, so overrun_cnt = 0.
- overrun_cnt saturates at 16'hFFFF.
- Select dropped while in ACK or HOLD: the FSM still completes to IDLE, and there are no side effects beyond the ACK cycle.
- Reset values: state=IDLE, Sl_xferAck=0, Sl_DBus=0, data_reg=C_RESET_VALUE, fresh=0, overrun_cnt=0, rd_reg=0.
- Reset mid-transfer aborts with no ack.

Decomposition:
- Shared package opb_sw_reg_pkg:
  - Offset constants OFF_DATA=0x0 and OFF_STATUS=0x4.
  - State enum {IDLE, ACK, HOLD}.
  - STATUS field positions.
  - OVR_MAX=16'hFFFF.
- One sub-module opb_slave_ack_fsm: address hit decode plus the IDLE/ACK/HOLD sequencing. It exposes rd_en, wr_en, offset and ack_cycle, and is reusable by both register directions.

Test Plan:
- Reset, then read DATA with C_RESET_VALUE=32'h0 -> Sl_DBus=0, one-cycle xferAck at k+1, STATUS reads 0.
- Pulse user_data_valid with 32'h12345678, then read DATA -> Sl_DBus[0:31]=32'h12345678; STATUS before the read = 0x1 and after = 0x0.
- Three valid pulses with no read -> STATUS=32'h00020001; write 0x4 with BE=4'hF -> STATUS=32'h00000001.
- DATA read ack coincides with a valid of 32'hCAFEBABE, old data 32'h11111111 -> read returns 32'h11111111; STATUS=0x1 with overrun 0; the next read returns 32'hCAFEBABE.
- Hold OPB_select high for 6 cycles -> exactly 2 acks, 3 cycles apart; Sl_DBus=0 on all non-ack cycles; an out-of-window address gives no ack.
- Drive 65540 overrunning pulses -> overrun_cnt=16'hFFFF; assert OPB_Rst_n low mid-ACK -> xferAck drops immediately and all state returns to its reset values.
